// File: rtl/xbar_mem_slave.sv
// xbar_mem_slave
//   Memory-backed responder for one slave port of the crossbar. It accepts a
//   request with a one-cycle ack. Writes go into a local word array. Reads
//   return rdata with a one-cycle resp pulse a fixed number of cycles after
//   the ack.
//
//   Optional feature macro: XBAR_SLV_ADDR_ERR_EN
//     When defined, the err port is present. Out-of-range accesses are flagged
//     on err. An out-of-range write does not modify the array, and an
//     out-of-range read returns 0.
//     When undefined, the upper index bits are dropped, so addresses alias
//     modulo MEM_DEPTH words.
//
// Ports
//   clk, rst_n  clock (rising edge); asynchronous active-low reset
//   req         request; addr/cmd/wdata are stable while req=1 and ack=0
//   addr        byte address; word index = addr[IDX_W+1:2], MSB ignored
//   cmd         0 = read, 1 = write
//   wdata       write data
//   ack         one-cycle accept pulse; the transfer occurs on the req&ack edge
//   resp        one-cycle read-data-valid pulse
//   rdata       read data; valid with resp and held until the next resp
//   err         (macro only) address error, asserted with ack or with resp
module xbar_mem_slave #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 256,
    parameter int ACK_DELAY    = 0,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  cmd,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ack,
    output logic                  resp,
    output logic [DATA_WIDTH-1:0] rdata
`ifdef XBAR_SLV_ADDR_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {IDLE, ACK_WAIT, ACK, READ_PEND, RESP} state_t;

    state_t                 state, state_n;
    logic [3:0]             cnt, cnt_n;
    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];
    logic [IDX_W-1:0]       idx, rd_idx, src_idx;
    logic                   oor, rd_oor, src_oor;
    logic                   wr_en, cap, load_rd;
    logic                   unused_addr;

    assign idx = addr[IDX_W+1:2];

`ifdef XBAR_SLV_ADDR_ERR_EN
    assign oor         = |addr[ADDR_WIDTH-2:IDX_W+2];
    assign unused_addr = ^{addr[ADDR_WIDTH-1], addr[1:0]};
`else
    assign oor         = 1'b0;
    assign unused_addr = ^{addr[ADDR_WIDTH-1:IDX_W+2], addr[1:0]};
`endif

    // With READ_LATENCY=1 the read loads in the same cycle it is captured,
    // so the captured index/flag must bypass the holding registers.
    assign src_idx = cap ? idx : rd_idx;
    assign src_oor = cap ? oor : rd_oor;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr_en   = 1'b0;
        cap     = 1'b0;
        load_rd = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (ACK_DELAY == 0) begin
                        state_n = ACK;
                    end else begin
                        state_n = ACK_WAIT;
                        cnt_n   = 4'(ACK_DELAY - 1);
                    end
                end
            end
            ACK_WAIT: begin
                if (!req)            state_n = IDLE;
                else if (cnt == '0)  state_n = ACK;
                else                 cnt_n   = cnt - 4'd1;
            end
            ACK: begin
                if (req && cmd) begin
                    wr_en   = !oor;
                    state_n = IDLE;
                end else if (req) begin
                    cap = 1'b1;
                    if (READ_LATENCY == 1) begin
                        state_n = RESP;
                        load_rd = 1'b1;
                    end else begin
                        state_n = READ_PEND;
                        cnt_n   = 4'(READ_LATENCY - 1);
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            READ_PEND: begin
                // Leaving at cnt==1 puts resp READ_LATENCY cycles after the ack.
                if (cnt <= 4'd1) begin
                    state_n = RESP;
                    load_rd = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            ack    <= 1'b0;
            resp   <= 1'b0;
            rdata  <= '0;
            rd_idx <= '0;
            rd_oor <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ack   <= (state_n == ACK);
            resp  <= (state_n == RESP);
            if (cap) begin
                rd_idx <= idx;
                rd_oor <= oor;
            end
            if (load_rd) rdata <= src_oor ? '0 : mem[src_idx];
        end
    end

`ifdef XBAR_SLV_ADDR_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= (state_n == ACK && cmd && oor) || (load_rd && src_oor);
    end
`endif

    // Array contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx] <= wdata;
    end

endmodule

// File: tb/tb_xbar_mem_slave.sv
module tb_xbar_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   [2];
    logic        cmd   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack   [2];
    logic        resp  [2];
    logic [31:0] rdata [2];
`ifdef XBAR_SLV_ADDR_ERR_EN
    logic        err   [2];
`endif

    int tests = 0;
    int fails = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    always #5 clk = ~clk;

    // Instance 0: default timing. Instance 1: ACK_DELAY=3.
    xbar_mem_slave u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .addr(addr[0]), .cmd(cmd[0]),
        .wdata(wdata[0]), .ack(ack[0]), .resp(resp[0]), .rdata(rdata[0])
`ifdef XBAR_SLV_ADDR_ERR_EN
        , .err(err[0])
`endif
    );

    xbar_mem_slave #(.ACK_DELAY(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .addr(addr[1]), .cmd(cmd[1]),
        .wdata(wdata[1]), .ack(ack[1]), .resp(resp[1]), .rdata(rdata[1])
`ifdef XBAR_SLV_ADDR_ERR_EN
        , .err(err[1])
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops the expected {err,rdata} whenever resp is seen.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (resp[k]) begin
                    if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_resp dut%0d: got resp=1 expected none", k);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("rdata_dut%0d", k), 64'(rdata[k]), 64'(e[31:0]));
`ifdef XBAR_SLV_ADDR_ERR_EN
                        check($sformatf("resp_err_dut%0d", k), 64'(err[k]), 64'(e[32]));
`endif
                    end
                end
            end
        end
    end

    // Called just after a posedge with the DUT idle. Checks the ack latency
    // (posedges until ack) and, for reads, the ack-to-resp latency.
    task automatic xfer(input int k, input logic c, input logic [31:0] a,
                        input logic [31:0] d, input int exp_lat, input logic [31:0] exp_rd,
                        input logic exp_err, input logic hold);
        int n = 0;
        req[k] = 1'b1; cmd[k] = c; addr[k] = a; wdata[k] = d;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack[k] && n < 20);
        check($sformatf("ack_lat_dut%0d_a%0h", k, a), 64'(n), 64'(exp_lat));
`ifdef XBAR_SLV_ADDR_ERR_EN
        check($sformatf("ack_err_dut%0d_a%0h", k, a), 64'(err[k]), 64'(c & exp_err));
`endif
        if (!c) begin
            if (k == 0) q0.push_back({exp_err, exp_rd});
            else        q1.push_back({exp_err, exp_rd});
        end
        @(posedge clk); #1;
        if (!hold) req[k] = 1'b0;
        if (!c) begin
            n = 1;
            while (!resp[k] && n < 20) begin
                @(posedge clk); #1; n++;
            end
            check($sformatf("resp_lat_dut%0d_a%0h", k, a), 64'(n), 64'd2);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; cmd[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
        end
        #12;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_ack%0d", k), 64'(ack[k]), 64'd0);
            check($sformatf("rst_resp%0d", k), 64'(resp[k]), 64'd0);
            check($sformatf("rst_rdata%0d", k), 64'(rdata[k]), 64'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write then read.
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 1, 0, 0, 0);
        xfer(0, 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, 0);

        // Back-to-back writes with req held high: acks on alternate cycles.
        xfer(0, 1'b1, 32'h0, 32'h1, 1, 0, 0, 1);
        xfer(0, 1'b1, 32'h4, 32'h2, 1, 0, 0, 0);
        xfer(0, 1'b0, 32'h0, 32'h0, 1, 32'h1, 0, 0);
        xfer(0, 1'b0, 32'h4, 32'h0, 1, 32'h2, 0, 0);

        // Reset during READ_PEND drops the read.
        req[0] = 1'b1; cmd[0] = 1'b0; addr[0] = 32'h10;
        @(posedge clk); #1;
        check("rst_test_ack", 64'(ack[0]), 64'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_ack", 64'(ack[0]), 64'd0);
        check("midrst_resp", 64'(resp[0]), 64'd0);
        check("midrst_rdata", 64'(rdata[0]), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("post_rst_resp", 64'(resp[0]), 64'd0);
        end

        // Address MSB is the routing bit and is ignored.
        xfer(0, 1'b1, 32'h8000_0010, 32'h55, 1, 0, 0, 0);
        xfer(0, 1'b0, 32'h0000_0010, 32'h0, 1, 32'h55, 0, 0);

        // Out-of-range address.
`ifdef XBAR_SLV_ADDR_ERR_EN
        xfer(0, 1'b1, 32'h400, 32'h99, 1, 0, 1, 0);
        xfer(0, 1'b0, 32'h400, 32'h0, 1, 32'h0, 1, 0);
        xfer(0, 1'b0, 32'h0, 32'h0, 1, 32'h1, 0, 0);
`else
        xfer(0, 1'b0, 32'h400, 32'h0, 1, 32'h1, 0, 0);
`endif

        // ACK_DELAY=3: ack four cycles after req; abandoned request writes nothing.
        xfer(1, 1'b1, 32'h20, 32'hA5, 4, 0, 0, 0);
        req[1] = 1'b1; cmd[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h77;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("abandon_ack_held", 64'(ack[1]), 64'd0);
        end
        req[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abandon_ack_dropped", 64'(ack[1]), 64'd0);
        end
        xfer(1, 1'b0, 32'h20, 32'h0, 4, 32'hA5, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(q0.size() + q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
